// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: debounced A -> B -> OP load sequencer for the TP1 ALU.
// Turns three raw push buttons plus the switch bank into ordered operand loads.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_buttons    raw buttons: [0] load A, [1] load B, [2] load operation
//   i_switches   operand / opcode value
//   o_data_a     operand A register
//   o_data_b     operand B register
//   o_operation  opcode register (low NB_OP switch bits)
//   o_alu_start  one-cycle strobe when a complete operand set is held
//   o_state      0 WAIT_A, 1 WAIT_B, 2 WAIT_OP, 3 READY
//   o_error      sticky out-of-order / simultaneous press flag
module alu_input_sequencer #(
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [2:0]         i_buttons,
    input  logic [NB_DATA-1:0] i_switches,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_alu_start,
    output logic [1:0]         o_state,
    output logic               o_error
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] WAIT_A  = 2'd0;
    localparam logic [1:0] WAIT_B  = 2'd1;
    localparam logic [1:0] WAIT_OP = 2'd2;
    localparam logic [1:0] READY   = 2'd3;

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] deb;
    logic [2:0] deb_d;
    logic [2:0] ev;

    // Two-flop synchronizer and the delayed debounced copy for edge detect.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            deb_d <= 3'b000;
        end else begin
            sync1 <= i_buttons;
            sync2 <= sync1;
            deb_d <= deb;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic [CW-1:0] cnt;
        logic          deb_q;

        // Level is accepted only after DEBOUNCE_CYCLES consecutive
        // mismatches; any agreeing sample restarts the run.
        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) begin
                cnt   <= '0;
                deb_q <= 1'b0;
            end else if (sync2[i] == deb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                deb_q <= ~deb_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[i] = deb_q;
    end

    assign ev = deb & ~deb_d;

    logic ev_a;
    logic ev_b;
    logic ev_op;
    logic multi;
    logic single;

    assign ev_a   = ev[0];
    assign ev_b   = ev[1];
    assign ev_op  = ev[2];
    assign multi  = (ev_a & ev_b) | (ev_a & ev_op) | (ev_b & ev_op);
    assign single = (|ev) & ~multi;

    logic [1:0]         state_n;
    logic [NB_DATA-1:0] a_n;
    logic [NB_DATA-1:0] b_n;
    logic [NB_OP-1:0]   op_n;
    logic               start_n;
    logic               err_n;

    always_comb begin
        state_n = o_state;
        a_n     = o_data_a;
        b_n     = o_data_b;
        op_n    = o_operation;
        start_n = 1'b0;
        err_n   = o_error;
        if (multi) begin
            err_n = 1'b1;
        end else if (single) begin
            unique case (o_state)
                WAIT_A: begin
                    unique case (1'b1)
                        ev_a: begin
                            a_n     = i_switches;
                            err_n   = 1'b0;
                            state_n = WAIT_B;
                        end
                        ev_b:  err_n = 1'b1;
                        ev_op: err_n = 1'b1;
                        default: ;
                    endcase
                end
                WAIT_B: begin
                    unique case (1'b1)
                        ev_a: a_n = i_switches;
                        ev_b: begin
                            b_n     = i_switches;
                            state_n = WAIT_OP;
                        end
                        ev_op: err_n = 1'b1;
                        default: ;
                    endcase
                end
                WAIT_OP: begin
                    unique case (1'b1)
                        ev_a: begin
                            a_n     = i_switches;
                            state_n = WAIT_B;
                        end
                        ev_b: b_n = i_switches;
                        ev_op: begin
                            op_n    = i_switches[NB_OP-1:0];
                            start_n = 1'b1;
                            state_n = READY;
                        end
                        default: ;
                    endcase
                end
                READY: begin
                    // B and OP keep their old values on a new A load.
                    unique case (1'b1)
                        ev_a: begin
                            a_n     = i_switches;
                            err_n   = 1'b0;
                            state_n = WAIT_B;
                        end
                        ev_b: err_n = 1'b1;
                        ev_op: begin
                            op_n    = i_switches[NB_OP-1:0];
                            start_n = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_n = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_state     <= WAIT_A;
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_operation <= '0;
            o_alu_start <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_state     <= state_n;
            o_data_a    <= a_n;
            o_data_b    <= b_n;
            o_operation <= op_n;
            o_alu_start <= start_n;
            o_error     <= err_n;
        end
    end

endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Front-end controller for the TP1 ALU board design. It takes the three raw push buttons and the switch bank and debounces each button. It then enforces the load order operand A → operand B → operation and drives the ALU operand/opcode registers. Once a complete operand set is held, it issues a one-cycle start strobe to the ALU. It replaces free-order button loading and sits between the board I/O and the ALU.

## Interface
- NB_DATA, 8, switch/operand width
- NB_OP, 6, opcode width; NB_OP <= NB_DATA
- DEBOUNCE_CYCLES, 4, consecutive stable cycles to accept a button level change; hardware build overrides with a larger value

- i_clock  in  1  system clock, rising-edge
- i_reset  in  1  asynchronous, active-low reset
- i_buttons  in  3  raw, bouncing, asynchronous buttons: [0] load A, [1] load B, [2] load operation
- i_switches  in  NB_DATA  operand/opcode value, assumed stable while a button is pressed
- o_data_a  out  NB_DATA  operand A register
- o_data_b  out  NB_DATA  operand B register
- o_operation  out  NB_OP  opcode register = i_switches[NB_OP-1:0] at capture
- o_alu_start  out  1  one-cycle pulse: complete operand set valid
- o_state  out  2  FSM state for LEDs: 0 WAIT_A, 1 WAIT_B, 2 WAIT_OP, 3 READY
- o_error  out  1  sticky out-of-order/simultaneous press flag

## Operation
- Per-button front end: 2-FF synchronizer → debouncer → rising-edge detector.
  - Debouncer keeps a debounced level `deb` and a counter.
  - The counter increments on each edge where the synchronized level differs from `deb`, and clears on any edge where they are equal.
  - On the DEBOUNCE_CYCLES-th consecutive mismatch, `deb` flips and the counter clears.
- Event: `deb` high while its 1-cycle-delayed copy is low. This gives exactly one event per accepted press.
  - Release, and glitches shorter than DEBOUNCE_CYCLES, produce no event.
- FSM acts only on cycles with exactly one event. If two or more events occur in the same cycle: set o_error, no load, no transition.
- WAIT_A:
  - A event → o_data_a <= i_switches, clear o_error, go to WAIT_B.
  - B or OP event → set o_error, stay.
- WAIT_B:
  - B event → o_data_b <= i_switches, go to WAIT_OP.
  - A event → reload o_data_a, stay.
  - OP event → set o_error.
- WAIT_OP:
  - OP event → o_operation <= i_switches[NB_OP-1:0], o_alu_start = 1, go to READY.
  - A event → reload o_data_a, go to WAIT_B.
  - B event → reload o_data_b, stay.
- READY:
  - OP event → reload o_operation and pulse o_alu_start again, stay. This allows a fast opcode change on the same operands.
  - A event → load o_data_a, clear o_error, go to WAIT_B. Operands B and op keep their old values until reloaded.
  - B event → set o_error, stay.
- o_error clears only on an accepted A load in WAIT_A or READY, or on reset.
- Registers are captured raw; no sign handling. Unused switch bits above NB_OP are ignored for the opcode.

## Timing
- Reset (i_reset = 0, asynchronous, no clock needed):
  - o_data_a, o_data_b, o_operation = 0.
  - o_alu_start = 0, o_state = 0, o_error = 0.
  - Synchronizers, debounced levels, delayed copies and counters = 0.
- Reset release: the first active edge is the first clock after i_reset goes high. A button held across release is treated as a new press (event after the normal latency).
- Press latency: let edge k be the first rising edge that samples the button high.
  - The synchronized level is high after edge k+1.
  - `deb` flips at edge k+1+DEBOUNCE_CYCLES.
  - The target register and o_state update at edge k+2+DEBOUNCE_CYCLES.
- o_alu_start is a registered output. It is high for exactly the one cycle following the edge that updates o_operation, then returns low.
- o_state and o_error are registered and update on the same edge as the associated load.
- Reset asserted mid-debounce or mid-sequence aborts everything. No pending event survives.

## Test plan
- Reset low, switches 0xFF, buttons toggling → all outputs 0, o_state 0, no o_alu_start, for at least 20 cycles.
- Hold each button 10 cycles then release 10 cycles (DEBOUNCE_CYCLES = 4):
  - A at 0x05, B at 0xFA, OP at 0x20.
  - Expect o_data_a = 0x05, o_data_b = 0xFA, o_operation = 6'h20.
  - Expect o_state 0→1→2→3.
  - Expect one o_alu_start pulse exactly 6 edges after OP is first sampled high.
- Five 1-cycle glitches on button A → no load, o_state 0. Then a 10-cycle hold → exactly one load.
- In WAIT_A, press B → o_error = 1, o_data_b stays 0, o_state 0. Then press A with 0x11 → o_error = 0, o_data_a = 0x11, o_state 1.
- In WAIT_B, press A and OP on the same cycle → o_error = 1, no register change, o_state 1.
- In READY, press OP with switches 0x0A → o_operation = 6'h0A, second single-cycle o_alu_start. Then drop i_reset between clock edges → all outputs 0 before the next rising edge.
